// File: rtl/run_sequencer.sv
// -----------------------------------------------------------------------------
// run_sequencer
//   Upstream controller for a run/done worker FSM. A host hands over a job of
//   N runs through a valid/ready handshake. The sequencer then issues N
//   single-cycle run pulses to the worker. It waits for the worker's done
//   pulse before issuing each next run. When the job ends it pulses
//   o_all_done for one cycle.
//
//   Optional feature: define RUN_SEQ_TIMEOUT_EN to add a per-run watchdog.
//   If the worker stays silent for TIMEOUT_CYCLES consecutive wait cycles,
//   the job is aborted and the sticky o_timeout flag is set. Without the
//   macro, no watchdog exists, o_timeout is tied low and a run waits forever.
//
// Parameters
//   NUM_W           width of the requested run count and completion counter
//   TO_W            width of the watchdog counter (watchdog build only)
//   TIMEOUT_CYCLES  wait cycles per run before abort, 1 .. 2**TO_W-1
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   i_req_valid  host request valid
//   o_req_ready  request can be accepted (idle only)
//   i_req_num    number of runs to issue, sampled on accept
//   o_run        one-cycle run pulse to the worker
//   i_done       worker completion pulse
//   o_busy       high whenever not idle
//   o_all_done   one-cycle pulse when a job finishes or is aborted
//   o_run_cnt    runs completed in the current/last job
//   o_timeout    sticky: last job aborted by the watchdog
// -----------------------------------------------------------------------------
module run_sequencer #(
  parameter int NUM_W          = 8,
  parameter int TO_W           = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [NUM_W-1:0] i_req_num,
  output logic             o_run,
  input  logic             i_done,
  output logic             o_busy,
  output logic             o_all_done,
  output logic [NUM_W-1:0] o_run_cnt,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Reject a watchdog limit that the counter cannot reach, or one of zero.
  generate
    if (TIMEOUT_CYCLES < 1 ||
        longint'(TIMEOUT_CYCLES) >= (longint'(1) << TO_W)) begin : g_bad_cfg
      $error("run_sequencer: TIMEOUT_CYCLES out of range for TO_W");
    end
  endgenerate

  state_t           state_reg;
  logic [NUM_W-1:0] num_reg;
  logic [NUM_W-1:0] run_cnt_reg;
  logic [NUM_W-1:0] run_cnt_next;

  // The count never passes num_reg, so this increment cannot wrap.
  assign run_cnt_next = run_cnt_reg + NUM_W'(1);

`ifdef RUN_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] wd_reg;
  logic            timeout_reg;
  logic            wd_expired;

  // wd_reg holds (wait cycles already spent) - so in the N-th wait cycle it
  // reads N-1. A match here means "this is the TIMEOUT_CYCLES-th cycle".
  assign wd_expired = (wd_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout  = timeout_reg;
`else
  assign o_timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      num_reg     <= '0;
      run_cnt_reg <= '0;
`ifdef RUN_SEQ_TIMEOUT_EN
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_req_valid) begin
            num_reg     <= i_req_num;
            run_cnt_reg <= '0;
`ifdef RUN_SEQ_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            // An empty job skips straight to the completion pulse.
            state_reg   <= (i_req_num != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
`ifdef RUN_SEQ_TIMEOUT_EN
          wd_reg    <= '0;
`endif
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // A done pulse on the expiry cycle still counts as a normal
          // completion, so it is checked first.
          if (i_done) begin
            run_cnt_reg <= run_cnt_next;
            state_reg   <= (run_cnt_next == num_reg) ? S_DONE : S_ISSUE;
          end
`ifdef RUN_SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            timeout_reg <= 1'b1;
            state_reg   <= S_DONE;
          end else begin
            wd_reg <= wd_reg + TO_W'(1);
          end
`endif
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decodes of the state register.
  assign o_req_ready = (state_reg == S_IDLE);
  assign o_busy      = (state_reg != S_IDLE);
  assign o_run       = (state_reg == S_ISSUE);
  assign o_all_done  = (state_reg == S_DONE);
  assign o_run_cnt   = run_cnt_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_run_sequencer
//   Directed bench for run_sequencer. Inputs are driven on the falling edge.
//   Outputs are sampled on the falling edge. A small worker model answers
//   each o_run with an i_done pulse WORKER_DLY falling edges later. With a
//   delay of 6, the run pulses come out 7 cycles apart. Build with
//   RUN_SEQ_TIMEOUT_EN to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_run_sequencer;

  localparam int NUM_W      = 8;
  localparam int TO_W       = 16;
  localparam int TMO        = 20;
  localparam int WORKER_DLY = 6;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_req_valid = 1'b0;
  logic [NUM_W-1:0] i_req_num = '0;
  logic             i_done = 1'b0;
  logic             o_req_ready;
  logic             o_run;
  logic             o_busy;
  logic             o_all_done;
  logic [NUM_W-1:0] o_run_cnt;
  logic             o_timeout;

  always #5 clk = ~clk;

  run_sequencer #(
    .NUM_W         (NUM_W),
    .TO_W          (TO_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_num  (i_req_num),
    .o_run      (o_run),
    .i_done     (i_done),
    .o_busy     (o_busy),
    .o_all_done (o_all_done),
    .o_run_cnt  (o_run_cnt),
    .o_timeout  (o_timeout)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  bit worker_en = 1'b0;
  bit wk_pend = 1'b0;
  int wk_cnt = 0;

  int runs_seen = 0;
  int dones_seen = 0;
  int run_cyc[16];
  int cnt_at_run[16];
  int done_cyc = 0;
  int cnt_at_done = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    runs_seen   = 0;
    dones_seen  = 0;
    done_cyc    = 0;
    cnt_at_done = 0;
  endtask

  // Advance to the next falling edge. Record what the DUT shows there.
  // Then let the worker model decide i_done for the following rising edge.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (worker_en) i_done = 1'b0;
    if (o_run) begin
      if (runs_seen < 16) begin
        run_cyc[runs_seen]    = cycle;
        cnt_at_run[runs_seen] = int'(o_run_cnt);
      end
      runs_seen++;
      if (worker_en) begin
        wk_pend = 1'b1;
        wk_cnt  = WORKER_DLY;
      end
    end else if (worker_en && wk_pend) begin
      wk_cnt--;
      if (wk_cnt == 0) begin
        i_done  = 1'b1;
        wk_pend = 1'b0;
      end
    end
    if (o_all_done) begin
      dones_seen++;
      done_cyc    = cycle;
      cnt_at_done = int'(o_run_cnt);
    end
  endtask

  // Present a request for one rising edge, then withdraw it.
  task automatic req(input int n);
    acc_cyc     = cycle;
    i_req_valid = 1'b1;
    i_req_num   = NUM_W'(n);
    cyc();
    i_req_valid = 1'b0;
  endtask

  initial begin
    // ---------------- 1: reset, including async assertion mid-cycle -------
    @(negedge clk);
    chk("rst_ready", o_req_ready, 1);
    chk("rst_busy", o_busy, 0);
    reset_n = 1'b1;
    cyc();
    req(1);
    chk("t1_run_before_rst", o_run, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_run", o_run, 0);
    chk("t1_async_busy", o_busy, 0);
    chk("t1_async_alldone", o_all_done, 0);
    chk("t1_async_cnt", o_run_cnt, 0);
    chk("t1_async_timeout", o_timeout, 0);
    chk("t1_async_ready", o_req_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // ---------------- 2: num=3 with worker, 7-cycle run spacing -----------
    clr_mon();
    worker_en = 1'b1;
    req(3);
    for (int i = 0; i < 80 && dones_seen == 0; i++) cyc();
    $display("job num=3 runs=%0d cnt=%0d all_done=%0d", runs_seen, cnt_at_done, dones_seen);
    chk("t2_runs", runs_seen, 3);
    chk("t2_first_lat", run_cyc[0] - acc_cyc, 1);
    chk("t2_space01", run_cyc[1] - run_cyc[0], 7);
    chk("t2_space12", run_cyc[2] - run_cyc[1], 7);
    chk("t2_cnt_run1", cnt_at_run[1], 1);
    chk("t2_cnt_run2", cnt_at_run[2], 2);
    chk("t2_done_lat", done_cyc - run_cyc[2], 7);
    chk("t2_dones", dones_seen, 1);
    chk("t2_cnt_done", cnt_at_done, 3);
    cyc();
    chk("t2_ready_after", o_req_ready, 1);
    chk("t2_busy_after", o_busy, 0);
    chk("t2_alldone_off", o_all_done, 0);
    cyc();
    chk("t2_cnt_hold", o_run_cnt, 3);

    // ---------------- 3: num=0 ---------------------------------------------
    clr_mon();
    req(0);
    $display("job num=0 all_done=%0d cnt=%0d", o_all_done, o_run_cnt);
    chk("t3_alldone", o_all_done, 1);
    chk("t3_done_lat", done_cyc - acc_cyc, 1);
    chk("t3_run", o_run, 0);
    chk("t3_cnt", o_run_cnt, 0);
    cyc();
    chk("t3_idle_ready", o_req_ready, 1);
    chk("t3_idle_alldone", o_all_done, 0);
    chk("t3_no_runs", runs_seen, 0);

    // ---------------- 4: spurious done, request while busy ----------------
    worker_en = 1'b0;
    clr_mon();
    i_done = 1'b1;
    cyc();
    i_done = 1'b0;
    chk("t4_idle_done_cnt", o_run_cnt, 0);
    req(2);
    chk("t4_issue", o_run, 1);
    // Done during the issue cycle, plus a second request held while busy.
    i_done      = 1'b1;
    i_req_valid = 1'b1;
    i_req_num   = NUM_W'(5);
    cyc();
    i_done = 1'b0;
    chk("t4_issue_done_cnt", o_run_cnt, 0);
    chk("t4_not_ready", o_req_ready, 0);
    repeat (3) cyc();
    chk("t4_wait_cnt", o_run_cnt, 0);
    chk("t4_wait_busy", o_busy, 1);
    i_done = 1'b1;
    cyc();
    i_done = 1'b0;
    chk("t4_run2", o_run, 1);
    chk("t4_cnt1", o_run_cnt, 1);
    cyc();
    i_done = 1'b1;
    cyc();
    i_done = 1'b0;
    chk("t4_alldone", o_all_done, 1);
    chk("t4_cnt2", o_run_cnt, 2);
    $display("job num=2 runs=%0d cnt=%0d all_done=%0d", runs_seen, o_run_cnt, dones_seen);
    cyc();
    chk("t4_idle_ready", o_req_ready, 1);
    chk("t4_idle_no_run", o_run, 0);
    // The held request is taken at this edge.
    clr_mon();
    worker_en = 1'b1;
    cyc();
    i_req_valid = 1'b0;
    chk("t4_second_run", o_run, 1);
    chk("t4_second_cnt", o_run_cnt, 0);
    for (int i = 0; i < 120 && dones_seen == 0; i++) cyc();
    $display("job num=5 runs=%0d cnt=%0d all_done=%0d", runs_seen, cnt_at_done, dones_seen);
    chk("t4_second_runs", runs_seen, 5);
    chk("t4_second_cnt_done", cnt_at_done, 5);
    cyc();

    // ---------------- 5: reset in WAIT after one done ---------------------
    clr_mon();
    req(4);
    for (int i = 0; i < 40 && o_run_cnt != 1; i++) cyc();
    chk("t5_cnt1", o_run_cnt, 1);
    cyc();
    chk("t5_in_wait", o_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_cnt", o_run_cnt, 0);
    chk("t5_rst_ready", o_req_ready, 1);
    wk_pend = 1'b0;
    clr_mon();
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (10) cyc();
    chk("t5_no_runs", runs_seen, 0);
    chk("t5_no_dones", dones_seen, 0);
    req(2);
    for (int i = 0; i < 60 && dones_seen == 0; i++) cyc();
    $display("job num=2 runs=%0d cnt=%0d all_done=%0d", runs_seen, cnt_at_done, dones_seen);
    chk("t5_fresh_runs", runs_seen, 2);
    chk("t5_fresh_cnt", cnt_at_done, 2);
    chk("t5_fresh_dones", dones_seen, 1);
    cyc();

    // ---------------- 6: worker never answers ------------------------------
    worker_en = 1'b0;
    i_done    = 1'b0;
    clr_mon();
    req(2);
    chk("t6_run", o_run, 1);
`ifdef RUN_SEQ_TIMEOUT_EN
    repeat (TMO) cyc();
    chk("t6_pre_timeout", o_timeout, 0);
    chk("t6_pre_busy", o_busy, 1);
    chk("t6_pre_dones", dones_seen, 0);
    cyc();
    $display("job num=2 timeout=%0d cnt=%0d all_done=%0d", o_timeout, o_run_cnt, o_all_done);
    chk("t6_alldone", o_all_done, 1);
    chk("t6_timeout", o_timeout, 1);
    chk("t6_cnt", o_run_cnt, 0);
    chk("t6_runs", runs_seen, 1);
    cyc();
    chk("t6_sticky", o_timeout, 1);
    chk("t6_idle", o_req_ready, 1);
    req(0);
    chk("t6_cleared", o_timeout, 0);
    cyc();
`else
    repeat (40) cyc();
    $display("job num=2 busy=%0d timeout=%0d all_done=%0d", o_busy, o_timeout, dones_seen);
    chk("t6_busy", o_busy, 1);
    chk("t6_timeout", o_timeout, 0);
    chk("t6_no_dones", dones_seen, 0);
    chk("t6_runs", runs_seen, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
